// File: rtl/pwm_fade_ctl.sv
// pwm_fade_ctl: CSR-programmable duty-cycle fader. Ramps a shadow duty value
// toward a target in fixed steps at a microsecond interval. Each new value is
// pushed into the sysctl PWM duty register through a second CSR master port.
module pwm_fade_ctl #(
  parameter logic [3:0]  csr_addr    = 4'h0,
  parameter logic [3:0]  sysctl_addr = 4'h0,
  parameter logic [4:0]  pwm_reg     = 5'b00111,
  parameter logic [31:0] clk_freq    = 32'd50000000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  output logic        m_req,
  input  logic        m_gnt,
  output logic [13:0] m_csr_a,
  output logic        m_csr_we,
  output logic [31:0] m_csr_do,
  output logic        fade_irq
);

  localparam logic [31:0] PRESC_DIV = clk_freq / 32'd1000000;
  localparam logic [7:0]  PRESC_MAX = 8'(PRESC_DIV - 32'd1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_CALC = 3'd2,
    S_REQ  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  presc_q, presc_d;
  logic [15:0] cnt_q, cnt_d;
  logic        irqen_q, irqen_d;
  logic [31:0] target_q, target_d;
  logic [31:0] step_q, step_d;
  logic [15:0] interval_q, interval_d;
  logic [31:0] current_q, current_d;
  logic [31:0] csr_do_q, csr_do_d;
  logic        m_req_q, m_req_d;
  logic        fade_irq_q, fade_irq_d;

  logic        csr_sel_s, wr_s, ctrl_wr_s, start_s, abort_s, tick_s, busy_s;
  logic [31:0] step_eff_s, next_val_s;
  logic [15:0] intv_eff_s;
  logic [32:0] sum_s, dif_s;
  logic        unused_s;

  assign unused_s   = ^csr_a[9:5];
  assign csr_sel_s  = (csr_a[13:10] == csr_addr);
  assign wr_s       = csr_sel_s & csr_we;
  assign ctrl_wr_s  = wr_s & (csr_a[4:0] == 5'b00000);
  assign abort_s    = ctrl_wr_s & csr_di[1];
  assign start_s    = ctrl_wr_s & csr_di[0] & ~csr_di[1];
  assign tick_s     = (presc_q == PRESC_MAX);
  assign busy_s     = (state_q != S_IDLE);
  assign step_eff_s = (step_q == 32'd0) ? 32'd1 : step_q;
  assign intv_eff_s = (interval_q == 16'd0) ? 16'd1 : interval_q;

  // Next duty value: one step toward TARGET in 33 bits, clamped so it never passes or wraps.
  always_comb begin
    sum_s      = {1'b0, current_q} + {1'b0, step_eff_s};
    dif_s      = {1'b0, current_q} - {1'b0, step_eff_s};
    next_val_s = current_q;
    if (current_q < target_q) begin
      if (sum_s >= {1'b0, target_q}) begin
        next_val_s = target_q;
      end else begin
        next_val_s = sum_s[31:0];
      end
    end else if (current_q > target_q) begin
      if (dif_s[32] || (dif_s[31:0] <= target_q)) begin
        next_val_s = target_q;
      end else begin
        next_val_s = dif_s[31:0];
      end
    end else begin
      next_val_s = current_q;
    end
  end

  // Register file updates, read mux, fade sequencer and registered outputs.
  always_comb begin
    presc_d    = tick_s ? 8'd0 : (presc_q + 8'd1);
    state_d    = state_q;
    cnt_d      = cnt_q;
    irqen_d    = irqen_q;
    target_d   = target_q;
    step_d     = step_q;
    interval_d = interval_q;
    current_d  = current_q;
    csr_do_d   = 32'd0;

    if (wr_s) begin
      case (csr_a[4:0])
        5'b00000: irqen_d    = csr_di[2];
        5'b00001: target_d   = csr_di;
        5'b00010: step_d     = csr_di;
        5'b00011: interval_d = csr_di[15:0];
        5'b00100: current_d  = busy_s ? current_q : csr_di;
        default:  current_d  = current_q;
      endcase
    end else begin
      current_d = current_q;
    end

    if (csr_sel_s) begin
      case (csr_a[4:0])
        5'b00000: csr_do_d = {29'd0, irqen_q, 1'b0, busy_s};
        5'b00001: csr_do_d = target_q;
        5'b00010: csr_do_d = step_q;
        5'b00011: csr_do_d = {16'd0, interval_q};
        5'b00100: csr_do_d = current_q;
        default:  csr_do_d = 32'd0;
      endcase
    end else begin
      csr_do_d = 32'd0;
    end

    case (state_q)
      S_IDLE: begin
        if (start_s) begin
          state_d = S_WAIT;
          cnt_d   = intv_eff_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (tick_s) begin
          if (cnt_q <= 16'd1) begin
            state_d = S_CALC;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_CALC: begin
        current_d = next_val_s;
        state_d   = S_REQ;
      end
      S_REQ: begin
        if (m_gnt) begin
          if (current_q == target_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
            cnt_d   = intv_eff_s;
          end
        end else begin
          state_d = S_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides whatever the sequencer chose, including a same-cycle START.
    if (abort_s) begin
      state_d = S_IDLE;
    end else begin
      state_d = state_d;
    end

    m_req_d    = (state_d == S_REQ);
    fade_irq_d = (state_d == S_DONE) & irqen_q;
  end

  // State and register flops with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      presc_q    <= 8'd0;
      cnt_q      <= 16'd0;
      irqen_q    <= 1'b0;
      target_q   <= 32'd0;
      step_q     <= 32'd0;
      interval_q <= 16'd1;
      current_q  <= 32'd0;
      csr_do_q   <= 32'd0;
      m_req_q    <= 1'b0;
      fade_irq_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      irqen_q    <= irqen_d;
      target_q   <= target_d;
      step_q     <= step_d;
      interval_q <= interval_d;
      current_q  <= current_d;
      csr_do_q   <= csr_do_d;
      m_req_q    <= m_req_d;
      fade_irq_q <= fade_irq_d;
    end
  end

  assign csr_do   = csr_do_q;
  assign m_req    = m_req_q;
  assign m_csr_we = m_req_q;
  assign m_csr_a  = {sysctl_addr, 5'b00000, pwm_reg};
  assign m_csr_do = current_q;
  assign fade_irq = fade_irq_q;

endmodule
